// File: rtl/control_unit_if.sv
// Control/status bundle between the instruction sequencer and the 8-bit data path.
// The sequencer side is the master; the data path side is the slave.
interface control_unit_if;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic       IR_Load;
    logic       MAR_Load;
    logic       PC_Load;
    logic       PC_Inc;
    logic       A_Load;
    logic       B_Load;
    logic [3:0] ALU_Sel;
    logic       CCR_Load;
    logic [1:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       write;

    modport master (
        input  IR, CCR_Result,
        output IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );

    modport slave (
        output IR, CCR_Result,
        input  IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
               ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write
    );
endinterface

// File: rtl/control_unit.sv
// Moore instruction sequencer: fetch, decode and per-opcode execute states driving
// the data path loads, bus selects, ALU select and memory write strobe.
module control_unit (
    input  logic                 clk,
    input  logic                 reset,
    control_unit_if.master       ctl
);

    localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDA_DIR = 8'h87,
                           OP_LDB_IMM = 8'h88, OP_LDB_DIR = 8'h89,
                           OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97,
                           OP_ADD_AB  = 8'h42, OP_SUB_AB  = 8'h43,
                           OP_AND_AB  = 8'h44, OP_OR_AB   = 8'h45,
                           OP_INCA    = 8'h46, OP_DECA    = 8'h47,
                           OP_INCB    = 8'h48, OP_DECB    = 8'h49,
                           OP_BRA     = 8'h20, OP_BEQ     = 8'h23,
                           OP_BCS     = 8'h25;

    localparam logic [1:0] BUS1_PC = 2'b00, BUS1_A = 2'b01, BUS1_B = 2'b10;
    localparam logic [1:0] BUS2_ALU = 2'b00, BUS2_BUS1 = 2'b01, BUS2_MEM = 2'b10;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_INC = 4'b0100, ALU_DEC = 4'b0101;

    typedef enum logic [5:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_LDA_IMM_4, S_LDA_IMM_5, S_LDA_IMM_6,
        S_LDB_IMM_4, S_LDB_IMM_5, S_LDB_IMM_6,
        S_LDA_DIR_4, S_LDA_DIR_5, S_LDA_DIR_6, S_LDA_DIR_7, S_LDA_DIR_8,
        S_LDB_DIR_4, S_LDB_DIR_5, S_LDB_DIR_6, S_LDB_DIR_7, S_LDB_DIR_8,
        S_STA_DIR_4, S_STA_DIR_5, S_STA_DIR_6, S_STA_DIR_7,
        S_STB_DIR_4, S_STB_DIR_5, S_STB_DIR_6, S_STB_DIR_7,
        S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4,
        S_INCA_4, S_DECA_4, S_INCB_4, S_DECB_4,
        S_BRA_4, S_BRA_5, S_BRA_6,
        S_BNT_4
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH_0;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH_0;
        ctl.IR_Load  = 1'b0;
        ctl.MAR_Load = 1'b0;
        ctl.PC_Load  = 1'b0;
        ctl.PC_Inc   = 1'b0;
        ctl.A_Load   = 1'b0;
        ctl.B_Load   = 1'b0;
        ctl.ALU_Sel  = ALU_ADD;
        ctl.CCR_Load = 1'b0;
        ctl.Bus1_Sel = BUS1_PC;
        ctl.Bus2_Sel = BUS2_ALU;
        ctl.write    = 1'b0;

        case (state_q)
            S_FETCH_0:   state_d = S_FETCH_1;
            S_FETCH_1:   state_d = S_FETCH_2;
            S_FETCH_2:   state_d = S_DECODE_3;
            S_DECODE_3: begin
                // Branch conditions are sampled here, so the taken path reuses BRA states.
                case (ctl.IR)
                    OP_LDA_IMM: state_d = S_LDA_IMM_4;
                    OP_LDB_IMM: state_d = S_LDB_IMM_4;
                    OP_LDA_DIR: state_d = S_LDA_DIR_4;
                    OP_LDB_DIR: state_d = S_LDB_DIR_4;
                    OP_STA_DIR: state_d = S_STA_DIR_4;
                    OP_STB_DIR: state_d = S_STB_DIR_4;
                    OP_ADD_AB:  state_d = S_ADD_AB_4;
                    OP_SUB_AB:  state_d = S_SUB_AB_4;
                    OP_AND_AB:  state_d = S_AND_AB_4;
                    OP_OR_AB:   state_d = S_OR_AB_4;
                    OP_INCA:    state_d = S_INCA_4;
                    OP_DECA:    state_d = S_DECA_4;
                    OP_INCB:    state_d = S_INCB_4;
                    OP_DECB:    state_d = S_DECB_4;
                    OP_BRA:     state_d = S_BRA_4;
                    OP_BEQ:     state_d = ctl.CCR_Result[2] ? S_BRA_4 : S_BNT_4;
                    OP_BCS:     state_d = ctl.CCR_Result[0] ? S_BRA_4 : S_BNT_4;
                    default:    state_d = S_FETCH_0;
                endcase
            end
            S_LDA_IMM_4: state_d = S_LDA_IMM_5;
            S_LDA_IMM_5: state_d = S_LDA_IMM_6;
            S_LDB_IMM_4: state_d = S_LDB_IMM_5;
            S_LDB_IMM_5: state_d = S_LDB_IMM_6;
            S_LDA_DIR_4: state_d = S_LDA_DIR_5;
            S_LDA_DIR_5: state_d = S_LDA_DIR_6;
            S_LDA_DIR_6: state_d = S_LDA_DIR_7;
            S_LDA_DIR_7: state_d = S_LDA_DIR_8;
            S_LDB_DIR_4: state_d = S_LDB_DIR_5;
            S_LDB_DIR_5: state_d = S_LDB_DIR_6;
            S_LDB_DIR_6: state_d = S_LDB_DIR_7;
            S_LDB_DIR_7: state_d = S_LDB_DIR_8;
            S_STA_DIR_4: state_d = S_STA_DIR_5;
            S_STA_DIR_5: state_d = S_STA_DIR_6;
            S_STA_DIR_6: state_d = S_STA_DIR_7;
            S_STB_DIR_4: state_d = S_STB_DIR_5;
            S_STB_DIR_5: state_d = S_STB_DIR_6;
            S_STB_DIR_6: state_d = S_STB_DIR_7;
            S_BRA_4:     state_d = S_BRA_5;
            S_BRA_5:     state_d = S_BRA_6;
            default:     state_d = S_FETCH_0;
        endcase

        case (state_q)
            // MAR <- PC, shared by instruction fetch, operand fetch and branch target fetch.
            S_FETCH_0, S_LDA_IMM_4, S_LDB_IMM_4, S_LDA_DIR_4, S_LDB_DIR_4,
            S_STA_DIR_4, S_STB_DIR_4, S_BRA_4: begin
                ctl.Bus1_Sel = BUS1_PC;
                ctl.Bus2_Sel = BUS2_BUS1;
                ctl.MAR_Load = 1'b1;
            end
            S_FETCH_1, S_LDA_IMM_5, S_LDB_IMM_5, S_LDA_DIR_5, S_LDB_DIR_5,
            S_STA_DIR_5, S_STB_DIR_5, S_BNT_4: begin
                ctl.PC_Inc = 1'b1;
            end
            S_FETCH_2: begin
                ctl.Bus2_Sel = BUS2_MEM;
                ctl.IR_Load  = 1'b1;
            end
            S_LDA_IMM_6, S_LDA_DIR_8: begin
                ctl.Bus2_Sel = BUS2_MEM;
                ctl.A_Load   = 1'b1;
            end
            S_LDB_IMM_6, S_LDB_DIR_8: begin
                ctl.Bus2_Sel = BUS2_MEM;
                ctl.B_Load   = 1'b1;
            end
            S_LDA_DIR_6, S_LDB_DIR_6, S_STA_DIR_6, S_STB_DIR_6: begin
                ctl.Bus2_Sel = BUS2_MEM;
                ctl.MAR_Load = 1'b1;
            end
            S_STA_DIR_7: begin
                ctl.Bus1_Sel = BUS1_A;
                ctl.write    = 1'b1;
            end
            S_STB_DIR_7: begin
                ctl.Bus1_Sel = BUS1_B;
                ctl.write    = 1'b1;
            end
            S_ADD_AB_4, S_SUB_AB_4, S_AND_AB_4, S_OR_AB_4, S_INCA_4, S_DECA_4: begin
                ctl.Bus1_Sel = BUS1_A;
                ctl.Bus2_Sel = BUS2_ALU;
                ctl.A_Load   = 1'b1;
                ctl.CCR_Load = 1'b1;
                case (state_q)
                    S_SUB_AB_4: ctl.ALU_Sel = ALU_SUB;
                    S_AND_AB_4: ctl.ALU_Sel = ALU_AND;
                    S_OR_AB_4:  ctl.ALU_Sel = ALU_OR;
                    S_INCA_4:   ctl.ALU_Sel = ALU_INC;
                    S_DECA_4:   ctl.ALU_Sel = ALU_DEC;
                    default:    ctl.ALU_Sel = ALU_ADD;
                endcase
            end
            S_INCB_4, S_DECB_4: begin
                ctl.Bus1_Sel = BUS1_B;
                ctl.Bus2_Sel = BUS2_ALU;
                ctl.B_Load   = 1'b1;
                ctl.CCR_Load = 1'b1;
                ctl.ALU_Sel  = (state_q == S_INCB_4) ? ALU_INC : ALU_DEC;
            end
            S_BRA_6: begin
                ctl.Bus2_Sel = BUS2_MEM;
                ctl.PC_Load  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
